// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with pixel clock enable, h/v counters, blanking, sync and frame count.
module video_timing_gen #(
  parameter int CEN_DIV  = 4,
  parameter int HW       = 9,
  parameter int VW       = 9,
  parameter int H_ACTIVE = 256,
  parameter int H_TOTAL  = 384,
  parameter int HS_START = 280,
  parameter int HS_LEN   = 32,
  parameter int V_ACTIVE = 224,
  parameter int V_TOTAL  = 264,
  parameter int VS_START = 240,
  parameter int VS_LEN   = 3
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pxl_cen,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          pxl_hb,
  output logic          pxl_vb,
  output logic          hs,
  output logic          vs,
  output logic [31:0]   frame_cnt,
  output logic          frame_pls
);
  localparam logic [3:0]    DMAX = 4'(CEN_DIV - 1);
  localparam logic [HW-1:0] HMAX = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VMAX = VW'(V_TOTAL - 1);
  // one extra bit so sync end positions equal to 2**HW / 2**VW still compare correctly
  localparam logic [HW:0]   HA   = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   HSS  = (HW+1)'(HS_START);
  localparam logic [HW:0]   HSE  = (HW+1)'(HS_START + HS_LEN);
  localparam logic [VW:0]   VA   = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   VSS  = (VW+1)'(VS_START);
  localparam logic [VW:0]   VSE  = (VW+1)'(VS_START + VS_LEN);
  logic [3:0]    div;
  logic          h_wrap, v_wrap;
  logic [HW:0]   h_nx;
  logic [VW:0]   v_nx;
  always_comb begin
    h_wrap = hcnt == HMAX;
    v_wrap = vcnt == VMAX;
    h_nx   = h_wrap ? '0 : {1'b0, hcnt} + 1'b1;
    v_nx   = h_wrap ? (v_wrap ? '0 : {1'b0, vcnt} + 1'b1) : {1'b0, vcnt};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      pxl_cen   <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
      pxl_hb    <= 1'b0;
      pxl_vb    <= 1'b0;
      hs        <= 1'b0;
      vs        <= 1'b0;
      frame_cnt <= '0;
      frame_pls <= 1'b0;
    end else begin
      div       <= div == DMAX ? '0 : div + 1'b1;
      pxl_cen   <= div == DMAX;
      frame_pls <= 1'b0;
      if (pxl_cen) begin
        hcnt      <= h_nx[HW-1:0];
        vcnt      <= v_nx[VW-1:0];
        pxl_hb    <= h_nx >= HA;
        pxl_vb    <= v_nx >= VA;
        hs        <= h_nx >= HSS && h_nx < HSE;
        vs        <= v_nx >= VSS && v_nx < VSE;
        frame_pls <= h_wrap && v_wrap;
        frame_cnt <= frame_cnt + 32'(h_wrap && v_wrap);
      end
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench running three configurations of video_timing_gen against a pixel-index model.
module tb_video_timing_gen;
  localparam int CEN [3] = '{4, 3, 1};
  localparam int HA  [3] = '{256, 12, 4};
  localparam int HT  [3] = '{384, 20, 8};
  localparam int HSS [3] = '{280, 14, 5};
  localparam int HSL [3] = '{32, 3, 2};
  localparam int VA  [3] = '{224, 6, 2};
  localparam int VT  [3] = '{264, 10, 4};
  localparam int VSS [3] = '{240, 7, 2};
  localparam int VSL [3] = '{3, 2, 1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        cen_o [3];
  logic        hb_o  [3];
  logic        vb_o  [3];
  logic        hs_o  [3];
  logic        vs_o  [3];
  logic        pls_o [3];
  logic [8:0]  h_o   [3];
  logic [8:0]  v_o   [3];
  logic [31:0] fc_o  [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    video_timing_gen #(
      .CEN_DIV(CEN[g]), .HW(9), .VW(9),
      .H_ACTIVE(HA[g]), .H_TOTAL(HT[g]), .HS_START(HSS[g]), .HS_LEN(HSL[g]),
      .V_ACTIVE(VA[g]), .V_TOTAL(VT[g]), .VS_START(VSS[g]), .VS_LEN(VSL[g])
    ) dut (
      .clk(clk), .rst(rst), .pxl_cen(cen_o[g]), .hcnt(h_o[g]), .vcnt(v_o[g]),
      .pxl_hb(hb_o[g]), .pxl_vb(vb_o[g]), .hs(hs_o[g]), .vs(vs_o[g]),
      .frame_cnt(fc_o[g]), .frame_pls(pls_o[g])
    );
  end
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", tag, got_v, exp_v, cyc);
    end
  endtask
  int unsigned edges [3];
  longint      pix   [3];
  bit          mcen  [3];
  bit          mpls  [3];
  logic [31:0] base  [3];
  logic [55:0] exp_q [$];
  function automatic logic [55:0] expv(int i);
    longint f = longint'(HT[i]) * VT[i];
    longint h = pix[i] % HT[i];
    longint v = (pix[i] / HT[i]) % VT[i];
    logic [31:0] fc = base[i] + 32'(pix[i] / f);
    return {mcen[i], h >= HA[i], v >= VA[i], h >= HSS[i] && h < HSS[i] + HSL[i],
            v >= VSS[i] && v < VSS[i] + VSL[i], mpls[i], 9'(h), 9'(v), fc};
  endfunction
  function automatic logic [55:0] got(int i);
    return {cen_o[i], hb_o[i], vb_o[i], hs_o[i], vs_o[i], pls_o[i], h_o[i], v_o[i], fc_o[i]};
  endfunction
  // model: pixel index advances on edges that see the enable; positions derive from it
  always @(posedge clk) begin : model
    bit prev;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        edges[i] = 0;
        pix[i] = 0;
        mcen[i] = 1'b0;
        mpls[i] = 1'b0;
        base[i] = '0;
      end else begin
        prev = mcen[i];
        edges[i]++;
        if (prev) pix[i]++;
        mcen[i] = (edges[i] % CEN[i]) == 0;
        mpls[i] = prev && (pix[i] % (longint'(HT[i]) * VT[i])) == 0;
      end
      exp_q.push_back(expv(i));
    end
  end
  always @(negedge clk) begin
    if (exp_q.size() == 3)
      for (int i = 0; i < 3; i++) chk($sformatf("sb%0d", i), 64'(got(i)), 64'(exp_q.pop_front()));
  end
  int acnt [3];
  int last_pls [3];
  always @(negedge clk) begin
    for (int i = 1; i < 3; i++) begin
      if (rst) begin
        acnt[i] = 0;
        last_pls[i] = -1;
      end else begin
        if (pls_o[i]) begin
          chk($sformatf("active_px%0d", i), 64'(acnt[i]), 64'(HA[i] * VA[i]));
          if (i == 2 && last_pls[i] >= 0) chk("frame_period", 64'(cyc - last_pls[i]), 64'd32);
          last_pls[i] = cyc;
          acnt[i] = 0;
        end
        if (cen_o[i] && !hb_o[i] && !vb_o[i]) acnt[i]++;
      end
    end
  end
  initial begin
    int rise [$];
    int hsn;
    bit phb;
    bit found;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out", 64'(got(0)), 64'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("cen_low", 64'(cen_o[0]), 64'd0);
    end
    @(negedge clk);
    chk("cen_first", 64'(cen_o[0]), 64'd1);
    @(negedge clk);
    chk("h_after_cen", 64'(h_o[0]), 64'd1);
    chk("cen_div1", 64'(cen_o[2]), 64'd1);
    // preload frame_cnt of the small config just below wrap
    #2;
    force g_dut[1].dut.frame_cnt = 32'hFFFF_FFFF;
    base[1] = 32'hFFFF_FFFF - 32'(pix[1] / (longint'(HT[1]) * VT[1]));
    #1;
    release g_dut[1].dut.frame_cnt;
    found = 1'b0;
    for (int k = 0; k < 700 && !found; k++) begin
      @(negedge clk);
      found = pls_o[1];
    end
    chk("wrap_seen", 64'(found), 64'd1);
    chk("fc_wrap", 64'(fc_o[1]), 64'd0);
    chk("fc_no_x", 64'($isunknown(fc_o[1])), 64'd0);
    hsn = 0;
    phb = hb_o[0];
    for (int k = 0; k < 5000 && rise.size() < 3; k++) begin
      @(negedge clk);
      if (rise.size() > 0 && hs_o[0] && cen_o[0]) hsn++;
      if (hb_o[0] && !phb) begin
        chk("hb_rise_h", 64'(h_o[0]), 64'd256);
        rise.push_back(cyc);
      end
      if (!hb_o[0] && phb) chk("hb_fall_h", 64'(h_o[0]), 64'd0);
      phb = hb_o[0];
    end
    chk("hb_rises", 64'(rise.size()), 64'd3);
    if (rise.size() == 3) chk("line_period", 64'(rise[2] - rise[1]), 64'd1536);
    chk("hs_pixels", 64'(hsn), 64'd64);
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      found = h_o[0] == 9'd100 && v_o[0] == 9'd3;
    end
    chk("mid_frame_seen", 64'(found), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst0", 64'(got(0)), 64'd0);
    chk("async_rst1", 64'(got(1)), 64'd0);
    chk("async_rst2", 64'(got(2)), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("cen_low_rst", 64'(cen_o[0]), 64'd0);
    end
    @(negedge clk);
    chk("cen_first_rst", 64'(cen_o[0]), 64'd1);
    chk("fc_after_rst", 64'(fc_o[0]), 64'd0);
    repeat (2000) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
